// File: rtl/fp32_to_fxp8_q_if.sv
// Stream bundle for the fp32 -> fixed-point converter: 32-bit float words in, 8-bit fixed words out.
interface fp32_to_fxp8_q_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_last;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data, m_last
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/fp32_to_fxp8_q.sv
// IEEE binary32 to signed WOI.WOF fixed point (round half away, saturating); 2-cycle latency,
// one word per cycle, valid/ready stall holds the output word and propagates back to s_ready.
module fp32_to_fxp8_q #(
   parameter int WOI = 1,
   parameter int WOF = 7
) (
   input  logic            clk,
   input  logic            rst,
   fp32_to_fxp8_q_if.slave bus,
   input  logic            clr,
   output logic [15:0]     sat_cnt
);
   typedef enum logic [1:0] {K_ZERO, K_NORM, K_INF, K_NAN} kind_t;

   // Only WOI+WOF == 8 is supported; the output word is fixed at 8 bits.
   localparam int W = WOI + WOF;
   localparam logic signed [9:0] EXP_BIAS = 10'(127 - WOF);
   localparam logic signed [9:0] EXP_HI   = 10'(W - 1);
   localparam logic signed [9:0] EXP_LO   = -10'sd1;
   localparam logic signed [9:0] RND_POS  = 10'sd22;
   localparam logic [8:0]        POS_LIM  = 9'((1 << (W - 1)) - 1);
   localparam logic [8:0]        NEG_LIM  = 9'(1 << (W - 1));
   localparam logic [7:0]        POS_SAT  = 8'(POS_LIM);
   localparam logic [7:0]        NEG_SAT  = 8'(NEG_LIM);

   logic               s1_valid;
   kind_t              s1_kind;
   logic               s1_sign;
   logic signed [9:0]  s1_exp;
   logic [23:0]        s1_mant;
   logic               s1_last;

   logic               q_valid;
   logic [7:0]         q_data;
   logic               q_last;
   logic               q_sat;

   logic               s2_load;
   logic               s1_load;
   kind_t              dec_kind;
   logic [7:0]         dec_exp;
   logic signed [9:0]  dec_off;

   assign s2_load     = !q_valid || bus.m_ready;
   assign s1_load     = !s1_valid || s2_load;
   assign bus.s_ready = s1_load;
   assign bus.m_valid = q_valid;
   assign bus.m_data  = q_data;
   assign bus.m_last  = q_last;

   // Stage 1: classify and turn the biased exponent into the leading-one bit position of q.
   assign dec_exp = bus.s_data[30:23];
   assign dec_off = $signed({2'b00, dec_exp}) - EXP_BIAS;

   always_comb begin
      dec_kind = K_NORM;
      if (dec_exp == 8'd0) begin
         dec_kind = K_ZERO;
      end else if (dec_exp == 8'hFF) begin
         dec_kind = (bus.s_data[22:0] != 23'd0) ? K_NAN : K_INF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_kind  <= K_ZERO;
         s1_sign  <= 1'b0;
         s1_exp   <= '0;
         s1_mant  <= '0;
         s1_last  <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= bus.s_valid;
         if (bus.s_valid) begin
            s1_kind <= dec_kind;
            s1_sign <= bus.s_data[31];
            s1_exp  <= dec_off;
            s1_mant <= {1'b1, bus.s_data[22:0]};
            s1_last <= bus.s_last;
         end
      end
   end

   // Stage 2: keep one bit below the integer LSB, add it back in, then saturate and sign.
   logic [4:0] shamt;
   logic [8:0] shifted;
   logic [9:0] rnd;
   logic [8:0] mag;
   logic       over;
   logic [7:0] res;
   logic       res_sat;

   always_comb begin
      shamt   = '0;
      shifted = '0;
      rnd     = '0;
      mag     = '0;
      over    = (s1_exp > EXP_HI);
      res     = '0;
      res_sat = 1'b0;
      if (!over && (s1_exp >= EXP_LO)) begin
         shamt   = 5'(RND_POS - s1_exp);
         shifted = 9'(s1_mant >> shamt);
         rnd     = {1'b0, shifted} + 10'd1;
         mag     = 9'(rnd >> 1);
      end
      case (s1_kind)
         K_INF: begin
            res     = s1_sign ? NEG_SAT : POS_SAT;
            res_sat = 1'b1;
         end
         K_NORM: begin
            if (s1_sign) begin
               if (over || (mag > NEG_LIM)) begin
                  res     = NEG_SAT;
                  res_sat = 1'b1;
               end else begin
                  res = 8'(~mag + 9'd1);
               end
            end else if (over || (mag > POS_LIM)) begin
               res     = POS_SAT;
               res_sat = 1'b1;
            end else begin
               res = mag[7:0];
            end
         end
         default: begin
            res     = '0;
            res_sat = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_data  <= 8'h00;
         q_last  <= 1'b0;
         q_sat   <= 1'b0;
      end else if (s2_load) begin
         q_valid <= s1_valid;
         if (s1_valid) begin
            q_data <= res;
            q_last <= s1_last;
            q_sat  <= res_sat;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt <= 16'd0;
      end else if (clr) begin
         sat_cnt <= 16'd0;
      end else if (q_valid && bus.m_ready && q_sat && (sat_cnt != 16'hFFFF)) begin
         sat_cnt <= sat_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_fp32_to_fxp8_q.sv
// Randomized and directed bench for fp32_to_fxp8_q against a real-arithmetic reference model.
module tb_fp32_to_fxp8_q;
   localparam int WOF = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] sat_cnt;

   fp32_to_fxp8_q_if ifc();

   fp32_to_fxp8_q #(.WOI(1), .WOF(WOF)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (ifc),
      .clr     (clr),
      .sat_cnt (sat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       l;
      bit         s;
      int         c;
   } exp_t;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         model_cnt = 0;
   bit         lat_chk = 1'b0;
   bit         rdy_rand = 1'b0;
   logic       rdy_val = 1'b1;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_d = 8'h00;
   logic       prev_l = 1'b0;
   exp_t       expq[$];
   logic [7:0] got[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: value = 1.f * 2^(e-127), scaled by 2^WOF, rounded half away from zero.
   function automatic void ref_conv(input logic [31:0] x, output logic [7:0] d, output bit sat);
      int  e;
      real mag;
      real r;
      e   = int'(x[30:23]);
      d   = 8'h00;
      sat = 1'b0;
      if (e == 255) begin
         if (x[22:0] == 23'd0) begin
            d   = x[31] ? 8'h80 : 8'h7F;
            sat = 1'b1;
         end
      end else if (e != 0) begin
         mag = real'(int'({9'd0, x[22:0]}) + 8388608) * (2.0 ** (e - 150 + WOF));
         r   = $floor(mag + 0.5);
         if (!x[31]) begin
            if (r > 127.0) begin
               d   = 8'h7F;
               sat = 1'b1;
            end else begin
               d = 8'(int'(r));
            end
         end else begin
            if (r > 128.0) begin
               d   = 8'h80;
               sat = 1'b1;
            end else begin
               d = 8'(-int'(r));
            end
         end
      end
   endfunction

   function automatic logic [31:0] rand_fp();
      int          sel = $urandom_range(0, 9);
      logic [22:0] f   = 23'($urandom);
      logic [7:0]  e   = 8'($urandom_range(112, 136));
      logic        s   = 1'($urandom);
      if (sel == 0) begin
         case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7F80_0000;
            3:       return 32'hFF80_0000;
            4:       return 32'h7FC0_0000;
            default: return {s, 8'h00, f};
         endcase
      end
      if (sel == 1) f = {f[22:16], 16'h0000};
      return {s, e, f};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      ifc.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ifc.m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         expq.delete();
         model_cnt  = 0;
         prev_stall = 1'b0;
         check("rst_m_valid", ifc.m_valid, 0);
         check("rst_m_data", ifc.m_data, 0);
         check("rst_sat_cnt", sat_cnt, 0);
      end else begin
         check("sat_cnt", sat_cnt, model_cnt);
         if (ifc.m_valid && prev_stall) begin
            check("stall_data", ifc.m_data, prev_d);
            check("stall_last", ifc.m_last, prev_l);
         end
         if (ifc.m_valid && ifc.m_ready) begin
            got.push_back(ifc.m_data);
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected no word", ifc.m_data);
            end else begin
               e = expq.pop_front();
               check("out_data", ifc.m_data, e.d);
               check("out_last", ifc.m_last, e.l);
               if (lat_chk) check("latency", cyc - e.c, 2);
               if (e.s && model_cnt != 65535) model_cnt++;
            end
         end
         if (clr) model_cnt = 0;
         if (ifc.s_valid && ifc.s_ready) begin
            ref_conv(ifc.s_data, e.d, e.s);
            e.l = ifc.s_last;
            e.c = cyc;
            expq.push_back(e);
         end
         prev_stall = ifc.m_valid && !ifc.m_ready;
         prev_d     = ifc.m_data;
         prev_l     = ifc.m_last;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] w, input logic l);
      bit done = 1'b0;
      ifc.s_valid = 1'b1;
      ifc.s_data  = w;
      ifc.s_last  = l;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         done = ifc.s_ready;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got s_ready=0 expected acceptance of %h", w);
      end
      ifc.s_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 500; i++) begin
         if (expq.size() == 0 && !ifc.m_valid) break;
         step(1);
      end
      step(1);
      check("drain_empty", expq.size(), 0);
   endtask

   initial begin
      logic [7:0] md;
      bit         ms;
      int         base;

      ifc.s_valid = 1'b0;
      ifc.s_data  = '0;
      ifc.s_last  = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset_m_valid", ifc.m_valid, 0);
      check("reset_m_data", ifc.m_data, 0);
      check("reset_m_last", ifc.m_last, 0);
      check("reset_sat_cnt", sat_cnt, 0);

      ref_conv(32'h3F00_0000, md, ms); check("model_0p5", md, 8'h40);
      ref_conv(32'hBF40_0000, md, ms); check("model_m0p75", md, 8'hA0);
      ref_conv(32'hBF80_0000, md, ms); check("model_m1_sat", ms, 0);
      ref_conv(32'h3B80_0000, md, ms); check("model_tie", md, 8'h01);
      ref_conv(32'h3F80_0000, md, ms); check("model_p1_sat", {md, 7'd0, ms}, {8'h7F, 8'h01});

      step(2);
      rst = 1'b0;
      @(negedge clk);
      check("s_ready_after_rst", ifc.s_ready, 1);
      step(1);

      lat_chk = 1'b1;
      base = got.size();
      send(32'h3F00_0000, 1'b0);
      send(32'hBF40_0000, 1'b0);
      send(32'hBF80_0000, 1'b1);
      drain();
      check("basic_0p5", got[base], 8'h40);
      check("basic_m0p75", got[base+1], 8'hA0);
      check("basic_m1", got[base+2], 8'h80);
      check("basic_sat_cnt", sat_cnt, 0);

      base = got.size();
      send(32'h3B80_0000, 1'b0);
      send(32'h3B00_0000, 1'b0);
      send(32'h3F80_0000, 1'b1);
      drain();
      check("round_tie", got[base], 8'h01);
      check("round_small", got[base+1], 8'h00);
      check("round_p1", got[base+2], 8'h7F);
      check("round_sat_cnt", sat_cnt, 1);

      base = got.size();
      send(32'h7FC0_0000, 1'b0);
      send(32'h7F80_0000, 1'b0);
      send(32'hFF80_0000, 1'b0);
      send(32'h8000_0000, 1'b1);
      drain();
      check("spec_nan", got[base], 8'h00);
      check("spec_pinf", got[base+1], 8'h7F);
      check("spec_ninf", got[base+2], 8'h80);
      check("spec_nzero", got[base+3], 8'h00);
      check("spec_sat_cnt", sat_cnt, 3);
      lat_chk = 1'b0;

      rdy_rand = 1'b1;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 16; i++) begin
            send(rand_fp(), 1'(i == 15));
            step($urandom_range(0, 2));
         end
      end
      for (int i = 0; i < 200; i++) begin
         send(rand_fp(), 1'($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
      end
      drain();
      rdy_rand = 1'b0;
      rdy_val  = 1'b1;
      step(2);

      for (int i = 0; i < 65540; i++) send(32'h7F80_0000, 1'b0);
      drain();
      check("cnt_preload", sat_cnt, 16'hFFFF);

      rdy_val = 1'b0;
      step(1);
      send(32'h7F80_0000, 1'b1);
      for (int i = 0; i < 20 && !ifc.m_valid; i++) step(1);
      check("clr_word_valid", ifc.m_valid, 1);
      rdy_val = 1'b1;
      step(1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      @(negedge clk);
      check("clr_priority", sat_cnt, 0);
      step(1);

      rdy_val = 1'b0;
      step(1);
      send(32'h3F00_0000, 1'b1);
      send(32'hBF40_0000, 1'b1);
      check("inflight_valid", ifc.m_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_m_valid", ifc.m_valid, 0);
      check("async_rst_m_data", ifc.m_data, 0);
      check("async_rst_m_last", ifc.m_last, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_val = 1'b1;
      @(negedge clk);
      check("s_ready_after_rst2", ifc.s_ready, 1);
      step(10);
      check("no_stale_output", got.size() > 0 ? 32'(expq.size()) : 32'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fp32_to_fxp8_q.md
FP32_TO_FXP8_Q -- requirements
Module: fp32_to_fxp8_q

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- WOI, 1, integer bits of output fixed-point including sign.
- WOF, 7, fractional bits of output fixed-point.
- WOI+WOF SHALL equal 8; any other combination is unsupported.

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- s_valid, in, 1, input word valid.
- s_ready, out, 1, input accepted when s_valid&s_ready.
- s_data, in, 32, IEEE-754 binary32 input.
- s_last, in, 1, end-of-vector marker, passed through aligned with data.
- m_valid, out, 1, output word valid.
- m_ready, in, 1, downstream accepts when m_valid&m_ready.
- m_data, out, 8, signed two's-complement fixed-point, WOI.WOF.
- m_last, out, 1, s_last delayed with its word.
- clr, in, 1, synchronous clear of sat_cnt.
- sat_cnt, out, 16, count of saturated conversions, sticks at 16'hFFFF.

Function
REQ-003 Two-stage pipeline, one word per cycle sustained; latency from input handshake to m_valid high is exactly 2 cycles when m_ready stays high.
- Stage 1: field decode, special-case classify, exponent offset e-127+WOF.
- Stage 2: shift, rounding, saturation, sign application.

REQ-004 Each stage register SHALL load when it is empty or the next stage is loading.
- s_ready = !stage1_valid | stage2_load.
- stage2_load = !m_valid | m_ready.
- No combinational path from s_valid to m_valid.

REQ-005 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
- No word is dropped or duplicated under any valid/ready pattern.

REQ-006 Conversion of normal inputs:
- Magnitude: q = |value|*2^WOF, rounded to nearest integer, ties away from zero.
- Sign is applied after rounding.

REQ-007 Saturation rules:
- Positive result > 127 -> 8'h7F.
- Negative magnitude > 128 -> 8'h80.
- Negative magnitude exactly 128 -> 8'h80, not counted as saturation.

REQ-008 Special cases:
- +/-zero and subnormals -> 8'h00.
- NaN -> 8'h00, not counted.
- +inf -> 8'h7F, counted.
- -inf -> 8'h80, counted.

REQ-009 Exponent range:
- Shifts placing the leading one above bit 8 are treated as overflow.
- Shifts placing it below the rounding bit yield 0.
- No wrap-around of the shift amount is permitted.

REQ-010 sat_cnt SHALL increment by 1 in the cycle an output handshake (m_valid&m_ready) transfers a saturated word.
- Held at 16'hFFFF once reached.
- clr=1 forces 0 on the next edge; clr has priority over a simultaneous increment.

REQ-011 m_last SHALL equal the s_last sampled with the same input word.

Reset
REQ-012 While rst=1, asynchronously and without waiting for a clock edge: m_valid=0, m_data=8'h00, m_last=0, sat_cnt=0, both stage-valid flags=0.
REQ-013 s_ready=1 in the first cycle after reset release.
REQ-014 Reset asserted mid-stream discards in-flight words; no word accepted before reset appears after it.

Verification
REQ-015 Basic values, m_ready=1:
- 0x3F000000 (0.5) -> 0x40.
- 0xBF400000 (-0.75) -> 0xA0.
- 0xBF800000 (-1.0) -> 0x80, sat_cnt unchanged.
- Each output appears 2 cycles after acceptance.
REQ-016 Rounding and saturation:
- 0x3B800000 (2^-8) -> 0x01 (tie away from zero).
- 0x3B000000 (2^-9) -> 0x00.
- 0x3F800000 (1.0) -> 0x7F, sat_cnt=1.
REQ-017 Specials:
- 0x7FC00000 -> 0x00.
- 0x7F800000 -> 0x7F.
- 0xFF800000 -> 0x80.
- 0x80000000 -> 0x00.
- sat_cnt increments by exactly 2.
REQ-018 Backpressure: stream 16 words, m_ready toggling randomly and s_valid gapped.
- Output sequence equals input order.
- m_data stable while stalled.
- m_last on word 16 only.
REQ-019 Counter:
- Preload by 65540 saturating words -> sat_cnt=0xFFFF.
- Assert clr together with a saturating handshake -> sat_cnt=0.
REQ-020 Reset with two words in flight -> m_valid=0 immediately, and no stale output after release.
